// File: rtl/bram_pkg.sv
// Shared types and defaults for the firmware bram read arbiter.
// Holds the memory size / out-of-range word defaults and the response tag.
package bram_pkg;

    localparam int unsigned MEM_BYTES_DEF = 4096;
    localparam logic [31:0] OOR_DATA_DEF  = 32'h0000_0000;

    typedef logic port_id_t;

    typedef struct packed {
        logic     valid;
        port_id_t owner;
        logic     oor;
    } rd_tag_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way grant logic: round-robin (RR_EN=1) or fixed priority to port 0.
// Ports: clk, rst, req0_i/req1_i in; gnt0_o/gnt1_o one-hot grant, owner_o = winner.
module rr_arb2
    import bram_pkg::*;
#(
    parameter bit RR_EN = 1'b1
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     req0_i,
    input  logic     req1_i,
    output logic     gnt0_o,
    output logic     gnt1_o,
    output port_id_t owner_o
);

    port_id_t rr_last_q;
    port_id_t rr_last_d;

    always_comb begin
        gnt0_o = 1'b0;
        gnt1_o = 1'b0;
        unique case ({req1_i, req0_i})
            2'b01: gnt0_o = 1'b1;
            2'b10: gnt1_o = 1'b1;
            2'b11: begin
                // Under contention the port that did not win last time goes.
                if (RR_EN && (rr_last_q == 1'b0)) begin
                    gnt1_o = 1'b1;
                end else begin
                    gnt0_o = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign owner_o = gnt1_o;

    always_comb begin
        rr_last_d = rr_last_q;
        if (gnt1_o) begin
            rr_last_d = 1'b1;
        end else if (gnt0_o) begin
            rr_last_d = 1'b0;
        end
    end

    // Reset to 1 so port 0 takes the first contended grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_last_q <= 1'b1;
        end else begin
            rr_last_q <= rr_last_d;
        end
    end

endmodule

// File: rtl/bram_read_arbiter.sv
// Shares the bram read port between instruction fetch (m0) and data load (m1).
// Ports: m*_req/addr in, m*_gnt/rvalid/rdata/err out; bram_addr out, bram_rdata in.
module bram_read_arbiter
    import bram_pkg::*;
#(
    parameter int unsigned        ADDR_W    = 32,
    parameter int unsigned        DATA_W    = 32,
    parameter int unsigned        MEM_BYTES = MEM_BYTES_DEF,
    parameter logic [DATA_W-1:0]  OOR_DATA  = DATA_W'(OOR_DATA_DEF),
    parameter bit                 RR_EN     = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req,
    input  logic [ADDR_W-1:0] m0_addr,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    output logic              m0_err,
    input  logic              m1_req,
    input  logic [ADDR_W-1:0] m1_addr,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              m1_err,
    output logic [ADDR_W-1:0] bram_addr,
    input  logic [DATA_W-1:0] bram_rdata
);

    port_id_t          owner;
    logic              gnt_any;
    logic [ADDR_W-1:0] gnt_addr;
    logic              gnt_oor;
    logic              addr_upd;
    logic [DATA_W-1:0] rsp_data;

    logic [ADDR_W-1:0] bram_addr_q;
    rd_tag_t           tag_q;
    rd_tag_t           tag_d;
    logic [DATA_W-1:0] rdata0_q;
    logic [DATA_W-1:0] rdata1_q;

    rr_arb2 #(
        .RR_EN(RR_EN)
    ) u_arb (
        .clk    (clk),
        .rst    (rst),
        .req0_i (m0_req),
        .req1_i (m1_req),
        .gnt0_o (m0_gnt),
        .gnt1_o (m1_gnt),
        .owner_o(owner)
    );

    assign gnt_any  = m0_gnt | m1_gnt;
    assign gnt_addr = owner ? m1_addr : m0_addr;
    assign gnt_oor  = gnt_addr >= ADDR_W'(MEM_BYTES);
    assign addr_upd = gnt_any & ~gnt_oor;

    // The bram samples this at the grant edge, so it must be combinational;
    // between grants (and on out-of-range ones) the last address is held.
    assign bram_addr = addr_upd ? gnt_addr : bram_addr_q;

    always_comb begin
        tag_d       = '0;
        tag_d.valid = gnt_any;
        tag_d.owner = owner;
        tag_d.oor   = gnt_any & gnt_oor;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bram_addr_q <= '0;
            tag_q       <= '0;
        end else begin
            bram_addr_q <= bram_addr;
            tag_q       <= tag_d;
        end
    end

    assign rsp_data  = tag_q.oor ? OOR_DATA : bram_rdata;
    assign m0_rvalid = tag_q.valid & (tag_q.owner == 1'b0);
    assign m1_rvalid = tag_q.valid & (tag_q.owner == 1'b1);
    assign m0_err    = m0_rvalid & tag_q.oor;
    assign m1_err    = m1_rvalid & tag_q.oor;

    // A port that does not own the response keeps showing its last word.
    assign m0_rdata = m0_rvalid ? rsp_data : rdata0_q;
    assign m1_rdata = m1_rvalid ? rsp_data : rdata1_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            rdata0_q <= m0_rdata;
            rdata1_q <= m1_rdata;
        end
    end

endmodule
